// File: rtl/imem_port_arbiter.sv
// Single-port instruction BRAM arbiter: fetch has fixed priority, aux is
// protected by a starvation counter, and read returns follow issue order.
module imem_port_arbiter #(
   parameter int ADDR_W       = 30,
   parameter int READ_LATENCY = 1,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fetch_req,
   input  logic [31:0]       fetch_addr,
   output logic              fetch_ready,
   output logic              fetch_data_valid,
   output logic [31:0]       fetch_data_out,
   input  logic              aux_req,
   input  logic              aux_we,
   input  logic [3:0]        aux_be,
   input  logic [31:0]       aux_addr,
   input  logic [31:0]       aux_wdata,
   output logic              aux_ready,
   output logic              aux_rdata_valid,
   output logic [31:0]       aux_rdata,
   output logic              mem_en,
   output logic [3:0]        mem_be,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   output logic              inv_valid,
   output logic [31:0]       inv_addr
);

   logic [3:0]              starve_cnt_q, starve_cnt_d;
   logic [READ_LATENCY-1:0] pipe_v_q, pipe_v_d;
   logic [READ_LATENCY-1:0] pipe_o_q, pipe_o_d;
   logic                    inv_valid_q, inv_valid_d;
   logic [31:0]             inv_addr_q, inv_addr_d;

   logic aux_force;
   logic grant_aux;
   logic grant_fetch;
   logic aux_wr;
   logic tail_v;
   logic tail_o;
   logic unused_bits;

   assign aux_force   = (starve_cnt_q == 4'(STARVE_LIMIT));
   assign fetch_ready = ~rst & ~aux_force;
   assign aux_ready   = ~rst & (aux_force | ~fetch_req);

   // A fetch_req raised during a forced cycle is dropped, not queued.
   assign grant_aux   = aux_req & aux_ready;
   assign grant_fetch = fetch_req & fetch_ready & ~grant_aux;
   assign aux_wr      = grant_aux & aux_we;

   always_comb begin
      mem_en    = grant_aux | grant_fetch;
      mem_be    = aux_wr ? aux_be : 4'h0;
      mem_wdata = aux_wdata;
      mem_addr  = grant_aux ? aux_addr[ADDR_W+1:2]
                            : fetch_addr[ADDR_W+1:2];
   end

   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (rst || grant_aux || !aux_req) begin
         starve_cnt_d = 4'd0;
      end else if (!aux_ready &&
                   starve_cnt_q < 4'(STARVE_LIMIT)) begin
         starve_cnt_d = starve_cnt_q + 4'd1;
      end
   end

   always_comb begin
      pipe_v_d    = '0;
      pipe_o_d    = '0;
      pipe_v_d[0] = (grant_fetch | grant_aux) & ~aux_wr;
      pipe_o_d[0] = grant_aux;
      for (int i = 1; i < READ_LATENCY; i++) begin
         pipe_v_d[i] = pipe_v_q[i-1];
         pipe_o_d[i] = pipe_o_q[i-1];
      end
      if (rst) begin
         pipe_v_d = '0;
      end
   end

   always_comb begin
      inv_valid_d = aux_wr;
      inv_addr_d  = aux_wr ? {aux_addr[31:2], 2'b00} : inv_addr_q;
      if (rst) begin
         inv_valid_d = 1'b0;
         inv_addr_d  = 32'h0;
      end
   end

   always_ff @(posedge clk) begin
      starve_cnt_q <= starve_cnt_d;
      pipe_v_q     <= pipe_v_d;
      pipe_o_q     <= pipe_o_d;
      inv_valid_q  <= inv_valid_d;
      inv_addr_q   <= inv_addr_d;
   end

   // Outputs are gated so a return landing during reset is never seen.
   assign tail_v           = pipe_v_q[READ_LATENCY-1];
   assign tail_o           = pipe_o_q[READ_LATENCY-1];
   assign fetch_data_valid = ~rst & tail_v & ~tail_o;
   assign aux_rdata_valid  = ~rst & tail_v & tail_o;
   assign fetch_data_out   = mem_rdata;
   assign aux_rdata        = mem_rdata;
   assign inv_valid        = ~rst & inv_valid_q;
   assign inv_addr         = inv_addr_q;

   assign unused_bits = ^{fetch_addr, aux_addr};

   a_fetch_proto : assert property (
      @(posedge clk) disable iff (rst) (fetch_req |-> fetch_ready)
   );

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Bench for imem_port_arbiter: directed scenarios plus random traffic
// against a cycle-level behavioural model and a bench-side BRAM.
`timescale 1ns/1ps
module tb_imem_port_arbiter;

   localparam int RL  = 2;
   localparam int LIM = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        fetch_req = 1'b0;
   logic [31:0] fetch_addr = 32'h0;
   logic        fetch_ready;
   logic        fetch_data_valid;
   logic [31:0] fetch_data_out;
   logic        aux_req = 1'b0;
   logic        aux_we = 1'b0;
   logic [3:0]  aux_be = 4'h0;
   logic [31:0] aux_addr = 32'h0;
   logic [31:0] aux_wdata = 32'h0;
   logic        aux_ready;
   logic        aux_rdata_valid;
   logic [31:0] aux_rdata;
   logic        mem_en;
   logic [3:0]  mem_be;
   logic [29:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        inv_valid;
   logic [31:0] inv_addr;

   always #5 clk = ~clk;

   imem_port_arbiter #(
      .ADDR_W(30),
      .READ_LATENCY(RL),
      .STARVE_LIMIT(LIM)
   ) u_dut (
      .clk(clk),
      .rst(rst),
      .fetch_req(fetch_req),
      .fetch_addr(fetch_addr),
      .fetch_ready(fetch_ready),
      .fetch_data_valid(fetch_data_valid),
      .fetch_data_out(fetch_data_out),
      .aux_req(aux_req),
      .aux_we(aux_we),
      .aux_be(aux_be),
      .aux_addr(aux_addr),
      .aux_wdata(aux_wdata),
      .aux_ready(aux_ready),
      .aux_rdata_valid(aux_rdata_valid),
      .aux_rdata(aux_rdata),
      .mem_en(mem_en),
      .mem_be(mem_be),
      .mem_addr(mem_addr),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .inv_valid(inv_valid),
      .inv_addr(inv_addr)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t",
                  name, act, exp, $time);
      end
   endtask

   // Bench BRAM: 256 words, fixed read latency RL
   logic [31:0] bmem [256];
   logic [31:0] rd_p [RL];
   logic [31:0] wr_word;
   bit          mem_init = 1'b0;

   assign mem_rdata = rd_p[RL-1];

   always @(posedge clk) begin
      if (!mem_init) begin
         for (int i = 0; i < 256; i++) bmem[i] <= $urandom;
         mem_init <= 1'b1;
      end else if (mem_en && mem_be != 4'h0) begin
         wr_word = bmem[mem_addr[7:0]];
         for (int b = 0; b < 4; b++)
            if (mem_be[b]) wr_word[8*b +: 8] = mem_wdata[8*b +: 8];
         bmem[mem_addr[7:0]] <= wr_word;
      end
      rd_p[0] <= (mem_en && mem_be == 4'h0) ? bmem[mem_addr[7:0]]
                                            : 32'hBAD0_0000;
      for (int i = 1; i < RL; i++) rd_p[i] <= rd_p[i-1];
   end

   // Behavioural model: outstanding reads carry their due cycle
   typedef struct {
      int          due;
      bit          own;
      logic [31:0] data;
   } rd_t;

   rd_t         q[$];
   int          cyc = 0;
   int          m_starve = 0;
   bit          m_inv_v = 1'b0;
   logic [31:0] m_inv_a = 32'h0;

   always @(negedge clk) begin : cmp
      rd_t         r;
      bit          frc, g_f, g_a, e_fv, e_av, e_fr, e_ar;
      logic [31:0] ga;
      logic [31:0] e_data;
      frc  = (m_starve == LIM);
      e_fr = !rst && !frc;
      e_ar = !rst && (frc || !fetch_req);
      g_a  = 1'b0;
      g_f  = 1'b0;
      if (!rst) begin
         if (frc && aux_req) g_a = 1'b1;
         else if (fetch_req) g_f = !frc;
         else if (aux_req) g_a = 1'b1;
      end
      ga     = g_a ? aux_addr : fetch_addr;
      e_fv   = 1'b0;
      e_av   = 1'b0;
      e_data = 32'h0;
      if (q.size() > 0 && q[0].due == cyc) begin
         r = q.pop_front();
         e_fv   = !rst && !r.own;
         e_av   = !rst && r.own;
         e_data = r.data;
      end
      chk("fetch_ready", 32'(fetch_ready), 32'(e_fr));
      chk("aux_ready", 32'(aux_ready), 32'(e_ar));
      chk("mem_en", 32'(mem_en), 32'(g_a | g_f));
      if (g_a || g_f) begin
         chk("mem_addr", 32'(mem_addr), {2'b00, ga[31:2]});
         chk("mem_be", 32'(mem_be), (g_a && aux_we) ? 32'(aux_be) : 32'h0);
         if (g_a && aux_we) chk("mem_wdata", mem_wdata, aux_wdata);
      end
      chk("fetch_data_valid", 32'(fetch_data_valid), 32'(e_fv));
      chk("aux_rdata_valid", 32'(aux_rdata_valid), 32'(e_av));
      if (e_fv) chk("fetch_data_out", fetch_data_out, e_data);
      if (e_av) chk("aux_rdata", aux_rdata, e_data);
      chk("inv_valid", 32'(inv_valid), 32'(m_inv_v && !rst));
      if (m_inv_v && !rst) chk("inv_addr", inv_addr, m_inv_a);

      if (rst) begin
         q.delete();
         m_starve = 0;
         m_inv_v  = 1'b0;
      end else begin
         if (g_f || (g_a && !aux_we)) begin
            r.due  = cyc + RL;
            r.own  = g_a;
            r.data = bmem[ga[9:2]];
            q.push_back(r);
         end
         m_inv_v = g_a && aux_we;
         m_inv_a = {aux_addr[31:2], 2'b00};
         if (g_a || !aux_req) m_starve = 0;
         else if (!e_ar && m_starve < LIM) m_starve = m_starve + 1;
      end
      cyc++;
   end

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   bit aux_done;
   bit aux_pend;

   initial begin
      repeat (3) next();
      chk("lit_rst_fetch_ready", 32'(fetch_ready), 32'h0);
      chk("lit_rst_mem_en", 32'(mem_en), 32'h0);
      rst = 1'b0;
      #1;
      chk("lit_post_rst_fetch_ready", 32'(fetch_ready), 32'h1);
      next();

      // fetch only
      for (int i = 0; i < 3; i++) begin
         fetch_req  = 1'b1;
         fetch_addr = 32'h100 + 32'(4 * i);
         #1;
         chk("lit_fetch_mem_addr", 32'(mem_addr), 32'h40 + 32'(i));
         chk("lit_fetch_aux_v", 32'(aux_rdata_valid), 32'h0);
         next();
      end
      fetch_req = 1'b0;
      repeat (RL + 1) next();

      // aux write with fetch idle
      aux_req   = 1'b1;
      aux_we    = 1'b1;
      aux_be    = 4'hF;
      aux_addr  = 32'h2004;
      aux_wdata = 32'hDEADBEEF;
      #1;
      chk("lit_wr_ready", 32'(aux_ready), 32'h1);
      chk("lit_wr_be", 32'(mem_be), 32'hF);
      chk("lit_wr_addr", 32'(mem_addr), 32'h801);
      next();
      aux_req = 1'b0;
      aux_we  = 1'b0;
      #1;
      chk("lit_inv_valid", 32'(inv_valid), 32'h1);
      chk("lit_inv_addr", inv_addr, 32'h2004);
      next();

      // starvation
      aux_done = 1'b0;
      for (int i = 0; i < 6; i++) begin
         fetch_req  = fetch_ready;
         fetch_addr = 32'h200 + 32'(4 * i);
         aux_req    = !aux_done;
         aux_we     = 1'b0;
         aux_addr   = 32'h300;
         #1;
         if (i < 4) chk("lit_starve_aux_ready", 32'(aux_ready), 32'h0);
         if (i == 4) begin
            chk("lit_force_fetch_ready", 32'(fetch_ready), 32'h0);
            chk("lit_force_aux_ready", 32'(aux_ready), 32'h1);
         end
         if (i == 5) chk("lit_resume_fetch_ready", 32'(fetch_ready), 32'h1);
         if (aux_req && aux_ready) aux_done = 1'b1;
         next();
      end
      fetch_req = 1'b0;
      aux_req   = 1'b0;
      repeat (RL + 1) next();

      // interleave fetch / aux read / fetch
      fetch_req  = 1'b1;
      fetch_addr = 32'h40;
      next();
      fetch_req = 1'b0;
      aux_req   = 1'b1;
      aux_addr  = 32'h44;
      #1;
      chk("lit_il_aux_ready", 32'(aux_ready), 32'h1);
      next();
      aux_req    = 1'b0;
      fetch_req  = 1'b1;
      fetch_addr = 32'h48;
      #1;
      chk("lit_il_fv0", 32'(fetch_data_valid), 32'h1);
      next();
      fetch_req = 1'b0;
      #1;
      chk("lit_il_av1", 32'(aux_rdata_valid), 32'h1);
      chk("lit_il_fv1", 32'(fetch_data_valid), 32'h0);
      next();
      #1;
      chk("lit_il_fv2", 32'(fetch_data_valid), 32'h1);
      next();

      // reset mid-operation
      fetch_req  = 1'b1;
      fetch_addr = 32'h80;
      next();
      fetch_req = 1'b0;
      rst       = 1'b1;
      #1;
      chk("lit_mid_rst_ready", 32'(fetch_ready), 32'h0);
      next();
      #1;
      chk("lit_mid_rst_fv", 32'(fetch_data_valid), 32'h0);
      next();
      rst = 1'b0;
      #1;
      chk("lit_post_mid_fv", 32'(fetch_data_valid), 32'h0);
      chk("lit_post_mid_ready", 32'(fetch_ready), 32'h1);
      next();

      // idle fetch with aux request
      aux_req  = 1'b1;
      aux_addr = 32'h10;
      #1;
      chk("lit_idle_aux_ready", 32'(aux_ready), 32'h1);
      next();
      aux_req = 1'b0;
      next();

      // random traffic
      aux_pend = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         rst = ($urandom_range(0, 299) == 0);
         if (!aux_pend && $urandom_range(0, 2) == 0) begin
            aux_pend  = 1'b1;
            aux_we    = ($urandom_range(0, 2) == 0);
            aux_be    = 4'($urandom_range(1, 15));
            aux_addr  = $urandom;
            aux_wdata = $urandom;
         end
         aux_req    = aux_pend;
         fetch_req  = !rst && fetch_ready && ($urandom_range(0, 3) != 0);
         fetch_addr = $urandom;
         #1;
         if (aux_req && aux_ready) aux_pend = 1'b0;
         next();
      end
      rst       = 1'b0;
      fetch_req = 1'b0;
      aux_req   = 1'b0;
      repeat (RL + 3) next();

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
